// File: rtl/riscy_pkg.sv
// riscy_pkg: shared types and constants for the ALU issue block.
//   alu_ctrl_t : ALU operation select driven on alu_ctrl
//   state_t    : issue FSM states
//   dec_t      : result of decoding one instruction word
//   decode()   : maps an RV32I word onto dec_t (legal / immediate / op)
package riscy_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic      legal;
        logic      use_imm;
        alu_ctrl_t ctrl;
    } dec_t;

    // Maps funct3 of the shared add/slt/or/and group onto an ALU op.
    function automatic logic f3_to_ctrl(input logic [2:0] f3, output alu_ctrl_t ctrl);
        ctrl = ALU_ADD;
        case (f3)
            F3_ADD:  begin ctrl = ALU_ADD; return 1'b1; end
            F3_SLT:  begin ctrl = ALU_SLT; return 1'b1; end
            F3_OR:   begin ctrl = ALU_OR;  return 1'b1; end
            F3_AND:  begin ctrl = ALU_AND; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        alu_ctrl_t  c;
        logic       ok;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        opcode    = instr[6:0];
        f3        = instr[14:12];
        f7        = instr[31:25];
        d.legal   = 1'b0;
        d.use_imm = 1'b0;
        d.ctrl    = ALU_ADD;
        ok        = f3_to_ctrl(f3, c);
        if (opcode == OP_REG) begin
            if (f7 == F7_BASE && ok) begin
                d.legal = 1'b1;
                d.ctrl  = c;
            end else if (f7 == F7_SUB && f3 == F3_ADD) begin
                d.legal = 1'b1;
                d.ctrl  = ALU_SUB;
            end
        end else if (opcode == OP_IMM) begin
            // funct7 bits are immediate bits here, so they are not checked
            if (ok) begin
                d.legal   = 1'b1;
                d.use_imm = 1'b1;
                d.ctrl    = c;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// regfile: 32x32 register file, x0 hard-wired to zero.
//   clk, rst_n            : clock, asynchronous active-low reset (clears all)
//   raddr1/rdata1         : operand read port 1 (combinational)
//   raddr2/rdata2         : operand read port 2 (combinational)
//   dbg_addr/dbg_data     : debug read port (combinational)
//   we, waddr, wdata      : write port; writes to x0 are dropped
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 is forced to zero on the read side as well, so it never depends on storage
    assign rdata1   = (raddr1   == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2   = (raddr2   == 5'd0) ? 32'd0 : regs[raddr2];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-issue sequencer for RV32I register/immediate ALU ops,
// driving an external ALU and writing results back to a local register file.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr : instruction offer; accepted when both high
//                              on a rising edge (in_ready only in IDLE,
//                              offers while busy are ignored, not queued)
//   alu_rs1/alu_rs2/alu_ctrl : registered ALU operands and op select
//   alu_rd/alu_z            : ALU result and zero flag, sampled on last EXEC edge
//   done                    : one-cycle pulse while in WB
//   done_illegal/done_z     : qualifiers of done, zero when done is low
//   dbg_addr/dbg_data       : combinational register-file debug read
// ALU_LAT (1..7): number of EXEC cycles the operands are held.
module alu_issue
    import riscy_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_rd,
    input  logic        alu_z,
    output logic        done,
    output logic        done_illegal,
    output logic        done_z,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic [2:0]  cnt_q;
    logic [31:0] res_q;
    logic        z_q;
    logic        ill_q;
    logic [31:0] rs1_q, rs2_q;
    alu_ctrl_t   ctrl_q;

    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm;
    dec_t        dec;
    logic        exec_last;
    logic        wb_we;

    assign dec       = decode(instr_q);
    assign imm       = {{20{instr_q[31]}}, instr_q[31:20]};
    assign exec_last = (cnt_q == 3'(ALU_LAT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; illegal encodings skip EXEC and go straight to WB
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_READ;
            ST_READ: state_d = dec.legal ? ST_EXEC : ST_WB;
            ST_EXEC: if (exec_last) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 32'd0;
            cnt_q   <= 3'd0;
            res_q   <= 32'd0;
            z_q     <= 1'b0;
            ill_q   <= 1'b0;
            rs1_q   <= 32'd0;
            rs2_q   <= 32'd0;
            ctrl_q  <= ALU_ADD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) instr_q <= in_instr;
                end
                ST_READ: begin
                    ill_q <= ~dec.legal;
                    cnt_q <= 3'd0;
                    // Operands only change on a legal READ; illegal ones leave
                    // the ALU inputs untouched.
                    if (dec.legal) begin
                        rs1_q  <= rs1_data;
                        rs2_q  <= dec.use_imm ? imm : rs2_data;
                        ctrl_q <= dec.ctrl;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (exec_last) begin
                        res_q <= alu_rd;
                        z_q   <= alu_z;
                    end
                end
                default: ;
            endcase
        end
    end

    // done and its qualifiers come straight from state so reset kills them at once
    assign in_ready     = (state_q == ST_IDLE);
    assign done         = (state_q == ST_WB);
    assign done_illegal = done & ill_q;
    assign done_z       = done & ~ill_q & z_q;
    assign wb_we        = done & ~ill_q;

    assign alu_rs1  = rs1_q;
    assign alu_rs2  = rs2_q;
    assign alu_ctrl = ctrl_q;

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1   (instr_q[19:15]),
        .rdata1   (rs1_data),
        .raddr2   (instr_q[24:20]),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_we),
        .waddr    (instr_q[11:7]),
        .wdata    (res_q)
    );

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=2.
// Handshake: an instruction is accepted on a rising edge where in_valid and
// in_ready are both high; inputs are driven and outputs sampled on the
// falling edge. Latency is the index of the first falling edge after the
// accepting edge at which done is seen, i.e. the edge count to done sampled.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic [4:0]  dbg_addr;

    logic        in_valid_a [2];
    logic        in_ready_a [2];
    logic [31:0] in_instr_a [2];
    logic [31:0] alu_rs1_a  [2];
    logic [31:0] alu_rs2_a  [2];
    logic [2:0]  alu_ctrl_a [2];
    logic [31:0] alu_rd_a   [2];
    logic        alu_z_a    [2];
    logic        done_a     [2];
    logic        done_ill_a [2];
    logic        done_z_a   [2];
    logic [31:0] dbg_data_a [2];

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt [2];
    logic [31:0] ops1_log [24];
    logic [31:0] ops2_log [24];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    alu_issue #(.ALU_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_instr(in_instr_a[0]),
        .alu_rs1(alu_rs1_a[0]), .alu_rs2(alu_rs2_a[0]), .alu_ctrl(alu_ctrl_a[0]),
        .alu_rd(alu_rd_a[0]), .alu_z(alu_z_a[0]),
        .done(done_a[0]), .done_illegal(done_ill_a[0]), .done_z(done_z_a[0]),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_a[0])
    );

    alu_issue #(.ALU_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_instr(in_instr_a[1]),
        .alu_rs1(alu_rs1_a[1]), .alu_rs2(alu_rs2_a[1]), .alu_ctrl(alu_ctrl_a[1]),
        .alu_rd(alu_rd_a[1]), .alu_z(alu_z_a[1]),
        .done(done_a[1]), .done_illegal(done_ill_a[1]), .done_z(done_z_a[1]),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_a[1])
    );

    // ---------------- external ALU model ----------------
    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return {31'd0, ($signed(a) < $signed(b))};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_rd_a[0] = alu_f(alu_ctrl_a[0], alu_rs1_a[0], alu_rs2_a[0]);
    assign alu_rd_a[1] = alu_f(alu_ctrl_a[1], alu_rs1_a[1], alu_rs2_a[1]);
    assign alu_z_a[0]  = (alu_rd_a[0] == 32'd0);
    assign alu_z_a[1]  = (alu_rd_a[1] == 32'd0);

    // Accept counter: inputs are stable at the rising edge, state updates after
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (in_valid_a[k] && in_ready_a[k]) acc_cnt[k]++;
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic rd_reg(input int sel, input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data_a[sel];
    endtask

    // Issue one instruction and follow it to done, checking latency, qualifiers,
    // pulse width, single accept and in_ready low while busy.
    task automatic issue(input int sel, input string name, input logic [31:0] instr,
                         input int exp_lat, input logic exp_ill, input logic exp_z,
                         input bit hold);
        int   n;
        int   lat;
        int   acc0;
        logic got_ill, got_z, ready_bad;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready_a[sel], 1'b1);
        in_valid_a[sel] = 1'b1;
        in_instr_a[sel] = instr;
        acc0      = acc_cnt[sel];
        n         = 0;
        lat       = -1;
        got_ill   = 1'b0;
        got_z     = 1'b0;
        ready_bad = 1'b0;
        while (n < 20 && lat < 0) begin
            @(negedge clk);
            n++;
            if (!hold) in_valid_a[sel] = 1'b0;
            ops1_log[n] = alu_rs1_a[sel];
            ops2_log[n] = alu_rs2_a[sel];
            if (done_a[sel]) begin
                lat     = n;
                got_ill = done_ill_a[sel];
                got_z   = done_z_a[sel];
            end
            if (in_ready_a[sel]) ready_bad = 1'b1;
        end
        in_valid_a[sel] = 1'b0;
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_done_illegal"}, got_ill, exp_ill);
        chk({name, "_done_z"}, got_z, exp_z);
        @(negedge clk);
        chk({name, "_done_width"}, done_a[sel], 1'b0);
        chk({name, "_qual_idle"}, {done_ill_a[sel], done_z_a[sel]}, 2'b00);
        chk({name, "_accepts"}, acc_cnt[sel] - acc0, 1);
        if (hold) chk({name, "_busy_ready"}, ready_bad, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        ill;
        logic        z;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [31:0] v;
        int          el;

        vecs[0]  = '{enc_i(12'd20, 5'd0, 3'b000, 5'd1), 5'd1, 32'd20, 1'b0, 1'b0};
        vecs[1]  = '{enc_i(12'd30, 5'd0, 3'b000, 5'd2), 5'd2, 32'd30, 1'b0, 1'b0};
        vecs[2]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 5'd3, 32'd50, 1'b0, 1'b0};
        vecs[3]  = '{enc_i(12'd8, 5'd0, 3'b000, 5'd4), 5'd4, 32'd8, 1'b0, 1'b0};
        vecs[4]  = '{enc_i(12'd3, 5'd0, 3'b000, 5'd5), 5'd5, 32'd3, 1'b0, 1'b0};
        vecs[5]  = '{enc_r(7'h20, 5'd5, 5'd4, 3'b000, 5'd6), 5'd6, 32'd5, 1'b0, 1'b0};
        vecs[6]  = '{enc_r(7'h20, 5'd1, 5'd1, 3'b000, 5'd7), 5'd7, 32'd0, 1'b0, 1'b1};
        vecs[7]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd8), 5'd8, 32'd20, 1'b0, 1'b0};
        vecs[8]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd9), 5'd9, 32'd30, 1'b0, 1'b0};
        vecs[9]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd10), 5'd10, 32'd1, 1'b0, 1'b0};
        vecs[10] = '{enc_i(12'd6, 5'd1, 3'b111, 5'd12), 5'd12, 32'd4, 1'b0, 1'b0};
        vecs[11] = '{enc_i(12'd3, 5'd1, 3'b110, 5'd13), 5'd13, 32'd23, 1'b0, 1'b0};
        vecs[12] = '{enc_i(12'hFFB, 5'd2, 3'b010, 5'd14), 5'd14, 32'd0, 1'b0, 1'b1};
        vecs[13] = '{enc_i(12'hFFF, 5'd0, 3'b000, 5'd11), 5'd11, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[14] = '{enc_i(12'd5, 5'd0, 3'b000, 5'd0), 5'd0, 32'd0, 1'b0, 1'b0};
        vecs[15] = '{32'h0000_0000, 5'd0, 32'd0, 1'b1, 1'b0};
        vecs[16] = '{enc_r(7'h20, 5'd2, 5'd1, 3'b111, 5'd15), 5'd15, 32'd0, 1'b1, 1'b0};

        // ---------------- reset ----------------
        rst_n       = 1'b0;
        dbg_addr    = 5'd0;
        acc_cnt[0]  = 0;
        acc_cnt[1]  = 0;
        for (int s = 0; s < 2; s++) begin
            in_valid_a[s] = 1'b0;
            in_instr_a[s] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready_a[0], 1'b1);
        chk("rst_in_ready1", in_ready_a[1], 1'b1);
        chk("rst_done", {done_a[0], done_ill_a[0], done_z_a[0]}, 3'b000);
        chk("rst_rs1", alu_rs1_a[0], 32'd0);
        chk("rst_rs2", alu_rs2_a[0], 32'd0);
        chk("rst_ctrl", alu_ctrl_a[0], 3'b000);
        rd_reg(0, 5'd5, v);
        chk("rst_x5", v, 32'd0);

        // ---------------- table: ALU_LAT=1 ----------------
        for (int i = 0; i < NV; i++) begin
            el = vecs[i].ill ? 2 : 3;
            issue(0, $sformatf("v%0d", i), vecs[i].instr, el, vecs[i].ill, vecs[i].z, 1'b0);
            rd_reg(0, vecs[i].rd, v);
            chk($sformatf("v%0d_reg", i), v, vecs[i].val);
            if (i == 13) begin
                chk("addi_m1_rs2", alu_rs2_a[0], 32'hFFFF_FFFF);
                chk("addi_m1_ctrl", alu_ctrl_a[0], 3'b000);
            end
            if (i == 9) chk("slt_ctrl", alu_ctrl_a[0], 3'b101);
            if (i == 5) chk("sub_ctrl", alu_ctrl_a[0], 3'b001);
        end

        // Illegal instructions leave operands from addi x0,x0,5 in place
        chk("ill_hold_rs1", alu_rs1_a[0], 32'd0);
        chk("ill_hold_rs2", alu_rs2_a[0], 32'd5);
        rd_reg(0, 5'd1, v);
        chk("ill_x1", v, 32'd20);
        rd_reg(0, 5'd3, v);
        chk("ill_x3", v, 32'd50);
        rd_reg(0, 5'd11, v);
        chk("ill_x11", v, 32'hFFFF_FFFF);

        // ---------------- in_valid held through a busy instruction ----------------
        issue(0, "hold", enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd16), 3, 1'b0, 1'b0, 1'b1);
        rd_reg(0, 5'd16, v);
        chk("hold_x16", v, 32'd50);

        // ---------------- ALU_LAT=2 ----------------
        issue(1, "l2_addi1", enc_i(12'd20, 5'd0, 3'b000, 5'd1), 4, 1'b0, 1'b0, 1'b0);
        issue(1, "l2_addi2", enc_i(12'd30, 5'd0, 3'b000, 5'd2), 4, 1'b0, 1'b0, 1'b0);
        issue(1, "l2_add", enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 4, 1'b0, 1'b0, 1'b0);
        chk("l2_exec1_rs1", ops1_log[2], 32'd20);
        chk("l2_exec2_rs1", ops1_log[3], 32'd20);
        chk("l2_exec1_rs2", ops2_log[2], 32'd30);
        chk("l2_exec2_rs2", ops2_log[3], 32'd30);
        rd_reg(1, 5'd3, v);
        chk("l2_x3", v, 32'd50);
        issue(1, "l2_ill", 32'h0000_0000, 2, 1'b1, 1'b0, 1'b0);

        // ---------------- reset during EXEC aborts add x3 ----------------
        begin
            logic saw_done;
            saw_done = 1'b0;
            @(negedge clk);
            in_valid_a[0] = 1'b1;
            in_instr_a[0] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
            @(negedge clk);
            in_valid_a[0] = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("abort_done_now", done_a[0], 1'b0);
            chk("abort_ready_now", in_ready_a[0], 1'b1);
            chk("abort_rs1_clr", alu_rs1_a[0], 32'd0);
            repeat (3) begin
                @(negedge clk);
                if (done_a[0]) saw_done = 1'b1;
            end
            rst_n = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (done_a[0]) saw_done = 1'b1;
            end
            chk("abort_no_done", saw_done, 1'b0);
            chk("abort_ready_after", in_ready_a[0], 1'b1);
            rd_reg(0, 5'd3, v);
            chk("abort_x3", v, 32'd0);
            rd_reg(0, 5'd1, v);
            chk("abort_x1", v, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends with a summary
    initial begin
        #200000;
        $display("FAIL timeout: got no-finish expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, giving the number of cycles operands are held on the ALU before its result is sampled (legal range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the instruction on in_instr is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an instruction.
REQ-006 SHALL have port in_instr, input, 32 bits: RV32I instruction word.
REQ-007 SHALL have ports alu_rs1 and alu_rs2, outputs, 32 bits each: ALU operands.
REQ-008 SHALL have port alu_ctrl, output, 3 bits: ALU op select (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-009 SHALL have port alu_rd, input, 32 bits: ALU result.
REQ-010 SHALL have port alu_z, input, 1 bit: ALU zero flag.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port done_illegal, output, 1 bit: qualifies done; the instruction was unsupported.
REQ-013 SHALL have port done_z, output, 1 bit: qualifies done; alu_z captured for this instruction.
REQ-014 SHALL have port dbg_addr, input, 5 bits, and port dbg_data, output, 32 bits: combinational register-file read port.

Function
REQ-015 SHALL implement FSM states IDLE, READ, EXEC, WB; in_ready SHALL be 1 only in IDLE.
REQ-016 On in_valid && in_ready, SHALL latch in_instr and go to READ; in_valid while busy SHALL be ignored, not queued.
REQ-017 In READ, SHALL decode opcode 0110011 with funct7 0000000 and funct3 000/111/110/010 as add/and/or/slt, with funct7 0100000 and funct3 000 as sub.
REQ-018 In READ, SHALL decode opcode 0010011 with funct3 000/111/110/010 as addi/andi/ori/slti; alu_rs2 SHALL be instr[31:20] sign-extended to 32 bits.
REQ-019 Any other encoding SHALL be illegal: READ to WB directly, no ALU update, no register write, done_illegal=1 with done.
REQ-020 For a legal instruction, alu_rs1, alu_rs2 and alu_ctrl SHALL be registered at the READ-to-EXEC edge and held constant until the next legal READ.
REQ-021 EXEC SHALL last exactly ALU_LAT cycles; alu_rd and alu_z SHALL be captured on the final EXEC edge.
REQ-022 WB SHALL last one cycle: done=1, write the captured result to register rd unless rd=0, then go to IDLE.
REQ-023 Latency SHALL be 2+ALU_LAT cycles from the accepting edge to done high for legal instructions, and 2 cycles for illegal ones; throughput is one instruction per 3+ALU_LAT cycles.
REQ-024 Register x0 SHALL always read 0; writes to x0 SHALL be dropped, but done is still pulsed.
REQ-025 A rs1/rs2 equal to the rd of the previous instruction SHALL read the written value; no bypass is needed, since the write completes in WB before IDLE.
REQ-026 done_illegal and done_z SHALL be 0 whenever done is 0.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and clear x1..x31, alu_rs1, alu_rs2, alu_ctrl, done, done_illegal and done_z to 0; in_ready SHALL be 1 after release.
REQ-028 Reset during READ, EXEC or WB SHALL abort the instruction: no write, no done pulse.

Structure
REQ-029 Package riscy_pkg SHALL hold the alu_ctrl enum, opcode/funct3/funct7 constants and the FSM state enum.
REQ-030 The 32x32 register file SHALL be sub-module regfile: two read ports plus the debug read port, one write port, async reset.

Verification
REQ-031 addi x1,x0,20; addi x2,x0,30; add x3,x1,x2 -> x3=50, each done exactly 3 cycles after accept (ALU_LAT=1).
REQ-032 addi x4,x0,8; addi x5,x0,3; sub x6,x4,x5 -> x6=5, done_z=0; sub x7,x1,x1 -> x7=0, done_z=1.
REQ-033 and x8,x1,x2 -> 20; or x9,x1,x2 -> 30; slt x10,x1,x2 -> 1; addi x11,x0,-1 -> alu_rs2=0xFFFFFFFF, x11=0xFFFFFFFF.
REQ-034 addi x0,x0,5 -> done, dbg x0=0; instr 0x00000000 -> done with done_illegal=1 two cycles after accept, all registers unchanged.
REQ-035 in_valid held high through a busy instruction -> in_ready=0 until after done, exactly one accept per instruction; rst_n low in EXEC of add x3 -> no done, x3=0.
REQ-036 ALU_LAT=2: add x3,x1,x2 -> done 4 cycles after accept, operands stable for both EXEC cycles.
